// File: rtl/teclado_pkg.sv
// Shared types and constants for the scanned matrix keypad with event FIFO.
package teclado_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_e;

    // Phone-style 4x4 layout indexed by row*4+col: * -> 0xE, # -> 0xF.
    localparam logic [0:15][3:0] KEYMAP_4X4 = {
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    function automatic int unsigned key_w(input int unsigned n_lin, input int unsigned n_col);
        int unsigned w;
        w = $clog2(n_lin * n_col);
        return (w < 4) ? 4 : w;
    endfunction

endpackage

// File: rtl/fifo_sincrono.sv
// Single-clock FIFO; a pop frees a slot for a push in the same cycle, no empty bypass.
module fifo_sincrono #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [CW-1:0]    count_q;
    logic             pop_ok_c;
    logic             push_ok_c;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CW'(DEPTH));
    assign pop_ok_c  = pop_i && !empty_o;
    assign push_ok_c = push_i && (!full_o || pop_ok_c);
    assign data_o    = mem_q[rd_q];
    assign count_o   = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok_c) begin
            mem_q[wr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_ok_c) wr_q <= wr_q + AW'(1);
            if (pop_ok_c)  rd_q <= rd_q + AW'(1);
            case ({push_ok_c, pop_ok_c})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/teclado_matricial_fifo.sv
// Matrix keypad scanner with debounce, auto-repeat and a buffered key event queue.
module teclado_matricial_fifo
    import teclado_pkg::*;
#(
    parameter int unsigned N_LIN           = 4,
    parameter int unsigned N_COL           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 100,
    parameter int unsigned SCAN_CYCLES     = 8,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned REPEAT_DELAY    = 1000,
    parameter int unsigned REPEAT_RATE     = 250,
    parameter int unsigned MAP_EN          = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [N_COL-1:0]                  col_matriz,
    input  logic                              repeat_en,
    output logic [N_LIN-1:0]                  lin_matriz,
    output logic [key_w(N_LIN, N_COL)-1:0]    tecla_value,
    output logic                              tecla_valid,
    input  logic                              tecla_ready,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
    output logic                              overflow,
    input  logic                              clr_overflow,
    output logic                              key_held
);

    localparam int unsigned KEY_W   = key_w(N_LIN, N_COL);
    localparam int unsigned ROW_W   = $clog2(N_LIN);
    localparam int unsigned COL_W   = $clog2(N_COL);
    localparam int unsigned IDX_W   = $clog2(N_LIN * N_COL);
    localparam int unsigned CNT_MAX = (DEBOUNCE_CYCLES > SCAN_CYCLES) ? DEBOUNCE_CYCLES : SCAN_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
    localparam bit          USE_MAP = (MAP_EN == 1) && (N_LIN == 4) && (N_COL == 4);

    logic [N_COL-1:0] col_s1_q, col_s2_q;
    state_e           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d, row_next_c;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic             first_q, first_d;
    logic [N_COL-1:0] pat_q, pat_d;
    logic             push_q, push_d;
    logic [KEY_W-1:0] code_q, code_d;
    logic [N_LIN-1:0] lin_q;
    logic             held_q;
    logic             ovf_q;
    logic [COL_W-1:0] col_idx_c;
    logic             found_c;
    logic [IDX_W-1:0] key_idx_c;
    logic [KEY_W-1:0] key_code_c;
    logic             full_c, empty_c, pop_c, drop_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s1_q <= '1;
            col_s2_q <= '1;
        end else begin
            col_s1_q <= col_matriz;
            col_s2_q <= col_s1_q;
        end
    end

    // Lowest-index active column wins when several are low.
    always_comb begin
        col_idx_c = '0;
        found_c   = 1'b0;
        for (int c = 0; c < int'(N_COL); c++) begin
            if (!found_c && !pat_q[c]) begin
                col_idx_c = COL_W'(c);
                found_c   = 1'b1;
            end
        end
    end

    assign key_idx_c  = IDX_W'(32'(row_q) * N_COL + 32'(col_idx_c));
    assign row_next_c = (row_q == ROW_W'(N_LIN - 1)) ? '0 : row_q + ROW_W'(1);

    generate
        if (USE_MAP) begin : g_map
            assign key_code_c = KEY_W'(KEYMAP_4X4[key_idx_c]);
        end else begin : g_lin
            assign key_code_c = KEY_W'(key_idx_c);
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        rep_d   = rep_q;
        first_d = first_q;
        pat_d   = pat_q;
        push_d  = 1'b0;
        code_d  = code_q;
        case (state_q)
            ST_SCAN: begin
                if (cnt_q >= CNT_W'(SCAN_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (col_s2_q != '1) begin
                        state_d = ST_DEBOUNCE;
                        pat_d   = col_s2_q;
                    end else begin
                        row_d = row_next_c;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (col_s2_q != pat_q) begin
                    state_d = ST_SCAN;
                    row_d   = row_next_c;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_d = ST_PRESSED;
                    push_d  = 1'b1;
                    code_d  = key_code_c;
                    cnt_d   = '0;
                    rep_d   = '0;
                    first_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PRESSED: begin
                if (col_s2_q == '1) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end else if (repeat_en) begin
                    if (first_q ? (rep_q >= REP_W'(REPEAT_DELAY - 1))
                                : (rep_q >= REP_W'(REPEAT_RATE - 1))) begin
                        push_d  = 1'b1;
                        rep_d   = '0;
                        first_d = 1'b0;
                    end else begin
                        rep_d = rep_q + REP_W'(1);
                    end
                end
            end
            ST_RELEASE: begin
                if (col_s2_q != '1) begin
                    cnt_d = '0;
                end else if (cnt_q >= CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_d = ST_SCAN;
                    row_d   = row_next_c;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_SCAN;
            row_q   <= '0;
            cnt_q   <= '0;
            rep_q   <= '0;
            first_q <= 1'b1;
            pat_q   <= '1;
            push_q  <= 1'b0;
            code_q  <= '0;
            lin_q   <= ~N_LIN'(1);
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            rep_q   <= rep_d;
            first_q <= first_d;
            pat_q   <= pat_d;
            push_q  <= push_d;
            code_q  <= code_d;
            lin_q   <= ~(N_LIN'(1) << row_d);
            held_q  <= (state_d == ST_PRESSED) || (state_d == ST_RELEASE);
        end
    end

    fifo_sincrono #(
        .WIDTH (KEY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_q),
        .data_i  (code_q),
        .pop_i   (pop_c),
        .data_o  (tecla_value),
        .full_o  (full_c),
        .empty_o (empty_c),
        .count_o (fifo_count)
    );

    assign tecla_valid = !empty_c;
    assign pop_c       = tecla_valid && tecla_ready;
    assign drop_c      = push_q && full_c && !pop_c;

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (drop_c) begin
            ovf_q <= 1'b1;
        end else if (clr_overflow) begin
            ovf_q <= 1'b0;
        end
    end

    assign lin_matriz = lin_q;
    assign overflow   = ovf_q;
    assign key_held   = held_q;

endmodule

// File: tb/tb_teclado_matricial_fifo.sv
// Self-checking bench: keypad model drives columns from the row strobe, scoreboard checks events.
module tb_teclado_matricial_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] col_m, lin_m, val;
    logic       repeat_en, ready, clr, valid, ovf, held;
    logic [2:0] cnt;

    logic [2:0] col2, cnt2;
    logic [1:0] lin2;
    logic [3:0] val2;
    logic       valid2, ovf2, held2;
    logic       ready2, repeat2, clr2;

    logic       k_pressed = 1'b0;
    int         k_row = 0;
    logic [3:0] k_pat = 4'hF;
    logic       k2_pressed = 1'b0;
    int         k2_row = 0;
    logic [2:0] k2_pat = 3'b111;

    int errors = 0;
    int checks = 0;
    int valid_cycles = 0;
    int valid2_cycles = 0;
    logic [3:0] exp_q[$];
    logic [3:0] got_q[$];
    logic [3:0] exp2_q[$];
    logic [3:0] got2_q[$];

    teclado_matricial_fifo dut (
        .clk(clk), .rst_n(rst_n), .col_matriz(col_m), .repeat_en(repeat_en),
        .lin_matriz(lin_m), .tecla_value(val), .tecla_valid(valid), .tecla_ready(ready),
        .fifo_count(cnt), .overflow(ovf), .clr_overflow(clr), .key_held(held)
    );

    teclado_matricial_fifo #(.N_LIN(2), .N_COL(3), .MAP_EN(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .col_matriz(col2), .repeat_en(repeat2),
        .lin_matriz(lin2), .tecla_value(val2), .tecla_valid(valid2), .tecla_ready(ready2),
        .fifo_count(cnt2), .overflow(ovf2), .clr_overflow(clr2), .key_held(held2)
    );

    // Pressed key pulls its columns low only while its row is strobed.
    always_comb col_m = (k_pressed && lin_m[k_row] == 1'b0) ? k_pat : 4'hF;
    always_comb col2  = (k2_pressed && lin2[k2_row] == 1'b0) ? k2_pat : 3'b111;

    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (valid) valid_cycles++;
            if (valid && ready) got_q.push_back(val);
            if (valid2) valid2_cycles++;
            if (valid2 && ready2) got2_q.push_back(val2);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int row, input logic [3:0] pat, input int hold);
        int n;
        n = 0;
        while (lin_m[row] !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL press_row_wait: row %0d never strobed, lin=%b", row, lin_m);
        end
        k_row = row; k_pat = pat; k_pressed = 1'b1;
        wait_cyc(hold);
        k_pressed = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_cyc(3);
        checks++; if (lin_m !== 4'b1110) begin errors++; $display("FAIL rst_lin: got %b want 1110", lin_m); end
        checks++; if (valid !== 1'b0)    begin errors++; $display("FAIL rst_valid: got %b want 0", valid); end
        checks++; if (val !== 4'h0)      begin errors++; $display("FAIL rst_value: got %h want 0", val); end
        checks++; if (cnt !== 3'd0)      begin errors++; $display("FAIL rst_count: got %0d want 0", cnt); end
        checks++; if (ovf !== 1'b0)      begin errors++; $display("FAIL rst_overflow: got %b want 0", ovf); end
        checks++; if (held !== 1'b0)     begin errors++; $display("FAIL rst_held: got %b want 0", held); end
        rst_n = 1'b1;
        wait_cyc(5);
    endtask

    task automatic test_single();
        int v0;
        logic [3:0] e;
        ready = 1'b1;
        v0 = valid_cycles;
        exp_q.push_back(4'h5);
        press(1, 4'b1101, 140);
        wait_cyc(50);
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL single_held_during_release: got %b want 1", held); end
        wait_cyc(60);
        checks++; if (held !== 1'b0) begin errors++; $display("FAIL single_held_after_release: got %b want 0", held); end
        checks++; if (valid_cycles - v0 != 1) begin errors++; $display("FAIL single_valid_cycles: got %0d want 1", valid_cycles - v0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin errors++; $display("FAIL single_event_missing: got none want %h", e); end
            else if (got_q[0] !== e) begin errors++; $display("FAIL single_event: got %h want %h", got_q[0], e); void'(got_q.pop_front()); end
            else void'(got_q.pop_front());
        end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL single_extra_events: got %0d want 0", got_q.size()); got_q.delete(); end
    endtask

    task automatic test_ordered();
        logic [3:0] e;
        ready = 1'b0;
        exp_q.push_back(4'hA);
        press(0, 4'b0111, 160);
        wait_cyc(120);
        exp_q.push_back(4'h0);
        press(3, 4'b1101, 160);
        wait_cyc(120);
        checks++; if (cnt !== 3'd2)   begin errors++; $display("FAIL ordered_count: got %0d want 2", cnt); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL ordered_valid: got %b want 1", valid); end
        checks++; if (val !== 4'hA)   begin errors++; $display("FAIL ordered_head: got %h want A", val); end
        ready = 1'b1;
        wait_cyc(5);
        ready = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin errors++; $display("FAIL ordered_event_missing: got none want %h", e); end
            else if (got_q[0] !== e) begin errors++; $display("FAIL ordered_event: got %h want %h", got_q[0], e); void'(got_q.pop_front()); end
            else void'(got_q.pop_front());
        end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL ordered_extra_events: got %0d want 0", got_q.size()); got_q.delete(); end
    endtask

    task automatic test_glitch();
        int v0, n;
        ready = 1'b1;
        v0 = valid_cycles;
        press(2, 4'b1011, 10);
        wait_cyc(150);
        checks++; if (valid_cycles != v0) begin errors++; $display("FAIL glitch_valid: got %0d valid cycles want 0", valid_cycles - v0); end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL glitch_events: got %0d want 0", got_q.size()); got_q.delete(); end
        checks++; if (held !== 1'b0) begin errors++; $display("FAIL glitch_held: got %b want 0", held); end
        n = 0;
        while (lin_m !== 4'b0111 && n < 100) begin @(negedge clk); n++; end
        checks++; if (n >= 100) begin errors++; $display("FAIL glitch_rescan: lin=%b want row3 strobe within 100", lin_m); end
    endtask

    task automatic test_overflow();
        int         rows[5];
        logic [3:0] pats[5];
        logic [3:0] codes[5];
        logic [3:0] e;
        rows  = '{0, 0, 0, 1, 1};
        pats  = '{4'b1110, 4'b1101, 4'b1011, 4'b1110, 4'b1011};
        codes = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h6};
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back(codes[i]);
            press(rows[i], pats[i], 160);
            wait_cyc(120);
        end
        checks++; if (cnt !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d want 4", cnt); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", ovf); end
        checks++; if (val !== 4'h1) begin errors++; $display("FAIL ovf_head_stable: got %h want 1", val); end
        clr = 1'b1;
        wait_cyc(1);
        clr = 1'b0;
        wait_cyc(1);
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", ovf); end
        ready = 1'b1;
        wait_cyc(10);
        ready = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin errors++; $display("FAIL ovf_event_missing: got none want %h", e); end
            else if (got_q[0] !== e) begin errors++; $display("FAIL ovf_event: got %h want %h", got_q[0], e); void'(got_q.pop_front()); end
            else void'(got_q.pop_front());
        end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL ovf_fifth_present: got %0d extra want 0", got_q.size()); got_q.delete(); end
        checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL ovf_drained: got %0d want 0", cnt); end
    endtask

    task automatic test_repeat();
        logic [3:0] e;
        ready = 1'b1;
        repeat_en = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(4'h1);
        press(0, 4'b1110, 1820);
        wait_cyc(150);
        repeat_en = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin errors++; $display("FAIL repeat_event_missing: got none want %h", e); end
            else if (got_q[0] !== e) begin errors++; $display("FAIL repeat_event: got %h want %h", got_q[0], e); void'(got_q.pop_front()); end
            else void'(got_q.pop_front());
        end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL repeat_extra_events: got %0d want 0", got_q.size()); got_q.delete(); end
    endtask

    task automatic test_small_matrix();
        int n;
        logic [3:0] e;
        exp2_q.push_back(4'h5);
        n = 0;
        while (lin2[1] !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        checks++; if (n >= 200) begin errors++; $display("FAIL small_row_wait: lin2=%b", lin2); end
        k2_row = 1; k2_pat = 3'b011; k2_pressed = 1'b1;
        wait_cyc(140);
        k2_pressed = 1'b0;
        wait_cyc(120);
        while (exp2_q.size() > 0) begin
            e = exp2_q.pop_front();
            checks++;
            if (got2_q.size() == 0) begin errors++; $display("FAIL small_event_missing: got none want %h", e); end
            else if (got2_q[0] !== e) begin errors++; $display("FAIL small_event: got %h want %h", got2_q[0], e); void'(got2_q.pop_front()); end
            else void'(got2_q.pop_front());
        end
        checks++; if (got2_q.size() != 0) begin errors++; $display("FAIL small_extra_events: got %0d want 0", got2_q.size()); got2_q.delete(); end
    endtask

    task automatic test_reset_mid();
        int n, v2;
        ready = 1'b0;
        press(1, 4'b1101, 160);
        wait_cyc(120);
        checks++; if (cnt !== 3'd1) begin errors++; $display("FAIL midrst_prefill: got %0d want 1", cnt); end
        n = 0;
        while (lin2[1] !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        checks++; if (n >= 200) begin errors++; $display("FAIL midrst_row_wait: lin2=%b", lin2); end
        k2_row = 1; k2_pat = 3'b011; k2_pressed = 1'b1;
        wait_cyc(50);
        rst_n = 1'b0;
        k2_pressed = 1'b0;
        wait_cyc(2);
        checks++; if (lin2 !== 2'b10)  begin errors++; $display("FAIL midrst_lin: got %b want 10", lin2); end
        checks++; if (valid2 !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", valid2); end
        checks++; if (val2 !== 4'h0)   begin errors++; $display("FAIL midrst_value: got %h want 0", val2); end
        checks++; if (cnt2 !== 3'd0)   begin errors++; $display("FAIL midrst_count: got %0d want 0", cnt2); end
        checks++; if (ovf2 !== 1'b0)   begin errors++; $display("FAIL midrst_overflow: got %b want 0", ovf2); end
        checks++; if (held2 !== 1'b0)  begin errors++; $display("FAIL midrst_held: got %b want 0", held2); end
        checks++; if (cnt !== 3'd0)    begin errors++; $display("FAIL midrst_main_count: got %0d want 0", cnt); end
        v2 = valid2_cycles;
        rst_n = 1'b1;
        wait_cyc(200);
        checks++; if (valid2_cycles != v2) begin errors++; $display("FAIL midrst_event_after: got %0d valid cycles want 0", valid2_cycles - v2); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL midrst_main_valid: got %b want 0", valid); end
    endtask

    initial begin
        rst_n = 1'b0; repeat_en = 1'b0; ready = 1'b0; clr = 1'b0;
        ready2 = 1'b1; repeat2 = 1'b0; clr2 = 1'b0;
        test_reset();
        test_single();
        test_ordered();
        test_glitch();
        test_overflow();
        test_repeat();
        test_small_matrix();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
